// File: rtl/stream_rr_arb.sv
// rtl/stream_rr_arb.sv - N-way round-robin stream merger with burst lock and one output register
//
// Merges N valid/ready input streams onto one registered output stream. An
// arbitration win locks the grant to that requester for up to BURST beats so
// bursts stay contiguous on the output; priority rotates from the last winner.
//
// Parameters:
//   WIDTH  data width of every stream
//   N      number of requesters (2..8)
//   BURST  maximum beats per grant (1..16)
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   in_data   N*WIDTH input data, requester i on [i*WIDTH +: WIDTH]
//   in_vld    per-requester valid
//   in_rdy    per-requester ready (at most one bit set)
//   out_data  registered merged data
//   out_src   requester index of out_data
//   out_vld   registered output valid
//   out_rdy   downstream ready
module stream_rr_arb #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_vld,
  output logic [N-1:0]         in_rdy,
  output logic [WIDTH-1:0]     out_data,
  output logic [$clog2(N)-1:0] out_src,
  output logic                 out_vld,
  input  logic                 out_rdy
);

  localparam int SW = $clog2(N);
  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {ARB, LOCK} state_t;

  state_t         state;
  logic [SW-1:0]  gnt;
  logic [SW-1:0]  last;
  logic [CW-1:0]  cnt;

  logic [SW-1:0]  arb_sel;
  logic           arb_hit;
  logic [SW-1:0]  sel;
  logic           sel_vld;
  logic           ld;
  logic           xfer;
  logic [WIDTH-1:0] sel_data;

  // The output register can accept a new beat whenever it is empty or being
  // drained this cycle, so a steady stream flows without bubbles.
  assign ld = !out_vld || out_rdy;

  // Rotating priority search starting at last+1. Walking the offsets from the
  // farthest to the nearest lets the nearest valid requester win by being the
  // final assignment.
  always_comb begin
    arb_sel = '0;
    arb_hit = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (in_vld[(int'(last) + k) % N]) begin
        arb_sel = SW'((int'(last) + k) % N);
        arb_hit = 1'b1;
      end
    end
  end

  // While locked, only the granted requester is considered; other valids are
  // ignored until the burst ends or the grantee runs dry.
  always_comb begin
    if (state == LOCK) begin
      sel     = gnt;
      sel_vld = in_vld[gnt];
    end else begin
      sel     = arb_sel;
      sel_vld = arb_hit;
    end
  end

  assign sel_data = in_data[int'(sel)*WIDTH +: WIDTH];
  assign xfer     = !rst && ld && sel_vld;

  // Gated by rst so no handshake can be offered while the block is held in
  // reset, even though the output register looks empty then.
  always_comb begin
    in_rdy = '0;
    if (xfer) begin
      in_rdy[sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_src  <= '0;
      state    <= ARB;
      cnt      <= '0;
      gnt      <= '0;
      last     <= SW'(N - 1);
    end else begin
      // Output register: load on a transfer, otherwise empty it when it is
      // free to change; data and source hold so they stay stable while empty.
      if (xfer) begin
        out_data <= sel_data;
        out_src  <= sel;
        out_vld  <= 1'b1;
      end else if (ld) begin
        out_vld  <= 1'b0;
      end

      case (state)
        ARB: begin
          if (xfer) begin
            gnt   <= sel;
            last  <= sel;
            cnt   <= CW'(1);
            state <= (BURST == 1) ? ARB : LOCK;
          end
        end
        LOCK: begin
          // Nothing moves while the output is stalled, so the burst count
          // and grant are frozen until the downstream accepts again.
          if (ld) begin
            if (in_vld[gnt]) begin
              cnt <= cnt + CW'(1);
              if (cnt == CW'(BURST - 1)) begin
                state <= ARB;
              end
            end else begin
              // Grantee went idle: release the lock, costing one empty cycle.
              state <= ARB;
            end
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: doc/stream_rr_arb.md
STREAM_RR_ARB -- requirements
Module: stream_rr_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width of every stream.
REQ-002 The block SHALL have parameter N, default 4, giving the number of requesters (2..8).
REQ-003 The block SHALL have parameter BURST, default 4, giving the maximum beats per grant (1..16).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, an asynchronous active-high reset.
REQ-006 The block SHALL have port in_data, input, N*WIDTH, with requester i on bits [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port in_vld, input, N, the per-requester valid.
REQ-008 The block SHALL have port in_rdy, output, N, the per-requester ready.
REQ-009 The block SHALL have port out_data, output, WIDTH, the registered merged data.
REQ-010 The block SHALL have port out_src, output, clog2(N), the requester index of out_data.
REQ-011 The block SHALL have port out_vld, output, 1, the registered output valid.
REQ-012 The block SHALL have port out_rdy, input, 1, the downstream ready.

Function
REQ-013 A transfer SHALL occur on input i when in_vld[i] and in_rdy[i] are both 1 at a rising edge, and on the output when out_vld and out_rdy are both 1.
REQ-014 Load enable SHALL be ld = !out_vld || out_rdy (combinational), giving one output register stage with full throughput and no bubble.
REQ-015 At most one in_rdy bit SHALL be 1 in any cycle, and in_rdy[i] SHALL be 1 only when ld=1 and i equals the selected requester sel.
REQ-016 The block SHALL have two states: ARB (unlocked) and LOCK (granted to gnt).
REQ-017 In ARB, sel SHALL be the first i with in_vld[i]=1, searching from (last+1) mod N upward with wrap-around; if no in_vld bit is set, no in_rdy bit SHALL be asserted.
REQ-018 When an ARB transfer occurs, the block SHALL set gnt=last=sel and cnt=1, and SHALL enter LOCK unless BURST=1.
REQ-019 In LOCK, sel SHALL equal gnt regardless of any other in_vld bit.
REQ-020 When a LOCK transfer occurs, cnt SHALL increment, and when cnt reaches BURST the block SHALL return to ARB.
REQ-021 In LOCK with ld=1 and in_vld[gnt]=0, the block SHALL return to ARB with no transfer that cycle, a one-cycle bubble.
REQ-022 In LOCK with ld=0, the state, cnt and gnt SHALL hold.
REQ-023 On an input transfer, out_data and out_src SHALL load in_data[sel] and sel, and out_vld SHALL be 1 the next cycle (latency 1).
REQ-024 On ld=1 with no input transfer, out_vld SHALL go to 0, and out_data/out_src SHALL hold their values.
REQ-025 While out_vld=1 and out_rdy=0, out_data, out_src and out_vld SHALL remain stable.
REQ-026 Simultaneous output drain and input load in one cycle SHALL yield a back-to-back output beat.
REQ-027 cnt SHALL be clog2(BURST+1) bits wide and SHALL never exceed BURST.

Reset
REQ-028 While rst=1, the block SHALL immediately force out_vld=0, out_data=0, out_src=0, state=ARB, cnt=0, gnt=0 and last=N-1, so that requester 0 has first priority.
REQ-029 While rst=1, in_rdy SHALL be all 0.
REQ-030 Reset asserted mid-burst SHALL discard any held beat and lock; the first grant after reset release SHALL follow REQ-017 from last=N-1.

Verification
REQ-031 The bench SHALL cover: N=4, BURST=4, in_vld=4'b1111, out_rdy=1 -> out_src sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0..., with out_vld=1 every cycle from cycle 1.
REQ-032 The bench SHALL cover: in_vld=4'b0101, each source driving a free-running counter starting at 0, out_rdy=1 -> four beats from src 0 (data 0..3), then four from src 2 (data 0..3), then src 0 (data 4..7).
REQ-033 The bench SHALL cover: src 1 only, valid dropped after 2 beats, then in_vld=4'b1001 -> two src 1 beats, one bubble cycle with out_vld=0, then src 3 granted before src 0.
REQ-034 The bench SHALL cover: out_rdy=0 for 5 cycles with a beat held -> out_data/out_src stable, in_rdy=0, cnt unchanged; on out_rdy=1 the burst resumes with no beat lost or duplicated.
REQ-035 The bench SHALL cover: BURST=1, all valid -> out_src rotates 0,1,2,3 every cycle.
REQ-036 The bench SHALL cover: rst pulsed mid-burst at cnt=2 -> out_vld=0 immediately, and the first grant after release is src 0 when in_vld[0]=1.
